uart_tx_arbiter: RTL and testbench

- Shares the UART transmit write port (wr_uart / w_data / tx_full) among NREQ byte-stream requesters.
- Grants one requester at a time, round-robin, and holds the grant for a whole packet.
- Frames every packet as header byte (HDR_BASE | id), then payload bytes, then an XOR checksum byte.
- Sits between client logic and the uart block's TX FIFO.

---
 rtl/uart_arb_pkg.sv | 43 ++++
 rtl/rr_arbiter.sv | 27 ++
 rtl/uart_tx_arbiter.sv | 149 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_arb_pkg;

  // Packet framing states.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHdr  = 2'd1,
    StData = 2'd2,
    StChk  = 2'd3
  } arb_state_e;

  localparam logic [7:0] HDR_BASE_DEF = 8'hA0;

  // Widest arbiter the helper function supports.
  localparam int unsigned RR_MAX  = 16;
  localparam int unsigned RR_ID_W = 4;

  // Next valid requester after ptr, scanning ptr+1, ptr+2, ... modulo nreq.
  // Returns 0 when nothing is valid; callers qualify with |valid.
  function automatic logic [RR_ID_W-1:0] rr_pick(input logic [RR_MAX-1:0]  valid,
                                                 input logic [RR_ID_W-1:0] ptr,
                                                 input int unsigned        nreq);
    logic [RR_ID_W-1:0] id;
    logic               hit;
    logic [RR_ID_W:0]   cand;
    id  = '0;
    hit = 1'b0;
    for (int unsigned k = 1; k <= RR_MAX; k++) begin
      if (k <= nreq) begin
        cand = {1'b0, ptr} + (RR_ID_W + 1)'(k);
        if (cand >= (RR_ID_W + 1)'(nreq)) begin
          cand = cand - (RR_ID_W + 1)'(nreq);
        end
        if (!hit && valid[cand[RR_ID_W-1:0]]) begin
          hit = 1'b1;
          id  = cand[RR_ID_W-1:0];
        end
      end
    end
    return id;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick among NREQ requesters.
module rr_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned ID_W = 2
) (
  input  logic [NREQ-1:0] valid,
  input  logic [ID_W-1:0] ptr,
  output logic [ID_W-1:0] pick,
  output logic            found
);

  logic [RR_MAX-1:0]  valid_ext;
  logic [RR_ID_W-1:0] ptr_ext;

  // Widen to the helper's fixed size and select the next requester after ptr.
  always_comb begin
    valid_ext             = '0;
    valid_ext[NREQ-1:0]   = valid;
    ptr_ext               = '0;
    ptr_ext[ID_W-1:0]     = ptr;
    pick  = ID_W'(rr_pick(valid_ext, ptr_ext, NREQ));
    found = |valid;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares the UART TX write port among NREQ byte streams, framing each
// packet as header, payload and XOR checksum.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned ID_W     = 2,
  parameter logic [7:0]  HDR_BASE = HDR_BASE_DEF,
  parameter int unsigned TO_CYC   = 1024,
  parameter int unsigned TO_W     = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  input  logic              tx_full,
  output logic              wr_uart,
  output logic [7:0]        w_data,
  output logic              busy,
  output logic [ID_W-1:0]   grant_id,
  output logic              pkt_done,
  output logic              abort
);

  arb_state_e      state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] grant_id_q, grant_id_d;
  logic [7:0]      chk_q, chk_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            aborted_q, aborted_d;

  logic [ID_W-1:0] pick;
  logic            found;
  logic            g_valid;
  logic            g_last;
  logic [7:0]      g_data;
  logic [7:0]      hdr_byte;

  rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_rr_arbiter (
    .valid (req_valid),
    .ptr   (rr_ptr_q),
    .pick  (pick),
    .found (found)
  );

  // Granted requester's lane.
  always_comb begin
    g_valid  = req_valid[grant_id_q];
    g_last   = req_last[grant_id_q];
    g_data   = req_data[{grant_id_q, 3'b000} +: 8];
    hdr_byte = HDR_BASE | 8'(grant_id_q);
  end

  // State register; reset abandons any packet in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      rr_ptr_q   <= ID_W'(NREQ - 1);
      grant_id_q <= '0;
      chk_q      <= '0;
      to_cnt_q   <= '0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      chk_q      <= chk_d;
      to_cnt_q   <= to_cnt_d;
      aborted_q  <= aborted_d;
    end
  end

  // Next-state and write-port control; every write is gated by ~tx_full.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    chk_d      = chk_q;
    to_cnt_d   = to_cnt_q;
    aborted_d  = aborted_q;
    req_ready  = '0;
    wr_uart    = 1'b0;
    w_data     = '0;
    pkt_done   = 1'b0;
    abort      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (found) begin
          grant_id_d = pick;
          chk_d      = '0;
          state_d    = StHdr;
        end
      end

      StHdr: begin
        wr_uart = ~tx_full;
        w_data  = hdr_byte;
        if (!tx_full) begin
          chk_d   = hdr_byte;
          state_d = StData;
        end
      end

      StData: begin
        req_ready[grant_id_q] = ~tx_full;
        wr_uart               = g_valid & ~tx_full;
        w_data                = g_data;
        if (g_valid && !tx_full) begin
          chk_d    = chk_q ^ g_data;
          to_cnt_d = '0;
          if (g_last) begin
            state_d = StChk;
          end
        end else if (to_cnt_q == TO_W'(TO_CYC - 1)) begin
          // Stalled too long, backpressure included: close with a poisoned checksum.
          aborted_d = 1'b1;
          state_d   = StChk;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      StChk: begin
        wr_uart = ~tx_full;
        w_data  = aborted_q ? ~chk_q : chk_q;
        if (!tx_full) begin
          pkt_done  = ~aborted_q;
          abort     = aborted_q;
          rr_ptr_d  = grant_id_q;
          aborted_d = 1'b0;
          to_cnt_d  = '0;
          state_d   = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  assign busy     = (state_q != StIdle);
  assign grant_id = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized traffic
// compared against a packet-level framing model.
module tb_uart_tx_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned ID_W = 2;
  localparam logic [7:0]  HDR  = 8'hA0;

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              tx_full;
  logic              wr_uart;
  logic [7:0]        w_data;
  logic              busy;
  logic [ID_W-1:0]   grant_id;
  logic              pkt_done;
  logic              abort;

  uart_tx_arbiter #(
    .NREQ     (NREQ),
    .ID_W     (ID_W),
    .HDR_BASE (HDR),
    .TO_CYC   (16),
    .TO_W     (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_full   (tx_full),
    .wr_uart   (wr_uart),
    .w_data    (w_data),
    .busy      (busy),
    .grant_id  (grant_id),
    .pkt_done  (pkt_done),
    .abort     (abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Per-requester byte queues: {last, byte}.
  logic [8:0] rq [NREQ][$];
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         n_done, n_abort, busy_cyc, abort_cyc, last_xfer_cyc;
  int         txmode;
  logic [63:0] full_mask;
  bit         noise;
  int         m_ptr;
  int         npk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr"},    32'(wr_uart),   0);
    check({tag, "_wdata"}, 32'(w_data),    0);
    check({tag, "_busy"},  32'(busy),      0);
    check({tag, "_gid"},   32'(grant_id),  0);
    check({tag, "_done"},  32'(pkt_done),  0);
    check({tag, "_abort"}, 32'(abort),     0);
    check({tag, "_ready"}, 32'(req_ready), 0);
  endtask

  task automatic gen_pkts(input int i, input int n);
    for (int p = 0; p < n; p++) begin
      int len;
      len = int'($urandom_range(1, 4));
      for (int b = 0; b < len; b++) begin
        rq[i].push_back({(b == len - 1), 8'($urandom)});
      end
    end
  endtask

  function automatic bit all_empty();
    bit e;
    e = 1'b1;
    for (int i = 0; i < NREQ; i++) if (rq[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  // Expected byte stream: whole packets in round-robin order among requesters
  // holding queued packets, each framed as header, payload, XOR of all.
  task automatic model_expect(output int np);
    logic [8:0] mq [NREQ][$];
    logic [7:0] sum;
    logic [8:0] e;
    int         idx;
    bit         fnd;
    for (int i = 0; i < NREQ; i++) mq[i] = rq[i];
    exp_q.delete();
    np = 0;
    forever begin
      fnd = 1'b0;
      idx = 0;
      for (int k = 1; k <= NREQ; k++) begin
        int p;
        p = (m_ptr + k) % NREQ;
        if (!fnd && mq[p].size() != 0) begin
          fnd = 1'b1;
          idx = p;
        end
      end
      if (!fnd) break;
      sum = HDR | 8'(idx);
      exp_q.push_back(sum);
      do begin
        e = mq[idx].pop_front();
        exp_q.push_back(e[7:0]);
        sum = sum ^ e[7:0];
      end while (!e[8]);
      exp_q.push_back(sum);
      m_ptr = idx;
      np++;
    end
  endtask

  // Cycle driver: called and returns at a negedge.
  task automatic run(input int max_cyc, input bit need_done);
    bit fin;
    logic [NREQ-1:0] noise_drv;
    fin = 1'b0;
    got_q.delete();
    n_done = 0; n_abort = 0; busy_cyc = 0; abort_cyc = -1; last_xfer_cyc = -1;
    for (int c = 0; c < max_cyc && !fin; c++) begin
      noise_drv = '0;
      for (int i = 0; i < NREQ; i++) begin
        if (rq[i].size() != 0) begin
          req_valid[i]      = 1'b1;
          req_data[8*i +: 8] = rq[i][0][7:0];
          req_last[i]       = rq[i][0][8];
        end else if (noise && busy) begin
          noise_drv[i]       = 1'b1;
          req_valid[i]       = 1'($urandom_range(0, 1));
          req_data[8*i +: 8] = 8'($urandom);
          req_last[i]        = 1'($urandom_range(0, 1));
        end else begin
          req_valid[i]       = 1'b0;
          req_data[8*i +: 8] = 8'($urandom);
          req_last[i]        = 1'b0;
        end
      end
      case (txmode)
        0:       tx_full = 1'b0;
        1:       tx_full = (c < 64) ? full_mask[c] : 1'b0;
        default: tx_full = ($urandom_range(0, 2) == 0);
      endcase
      #4;
      check("no_write_when_full", 32'(wr_uart & tx_full), 0);
      check("ready_blocked_by_full", 32'((|req_ready) & tx_full), 0);
      check("ready_onehot", 32'($countones(req_ready) <= 1), 1);
      if (|noise_drv) check("isolation_ready", 32'(req_ready & noise_drv), 0);
      if (wr_uart) got_q.push_back(w_data);
      if (busy) busy_cyc++;
      if (pkt_done) n_done++;
      if (abort) begin
        n_abort++;
        abort_cyc = c;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i] && rq[i].size() != 0) begin
          void'(rq[i].pop_front());
          last_xfer_cyc = c;
        end
      end
      if (need_done && !busy && all_empty()) fin = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    if (need_done) check("run_completes", 32'(fin), 1);
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      check(tag, 32'(got_q[k]), 32'(exp_q[k]));
    end
  endtask

  initial begin
    reset = 1'b0; req_valid = '0; req_data = '0; req_last = '0; tx_full = 1'b0;
    txmode = 0; full_mask = '0; noise = 1'b0; m_ptr = NREQ - 1;

    // Reset state.
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b1;
    @(negedge clk);

    // Single packet from req1: A1 11 22 92, four busy cycles.
    rq[1].push_back(9'h011);
    rq[1].push_back(9'h122);
    model_expect(npk);
    run(100, 1'b1);
    compare_stream("single");
    if (got_q.size() == 4) check("single_chk_byte", 32'(got_q[3]), 32'h92);
    check("single_done", 32'(n_done), 1);
    check("single_abort", 32'(n_abort), 0);
    check("single_busy_cycles", 32'(busy_cyc), 4);

    // Round-robin between req0 and req2, one-byte packets.
    for (int p = 0; p < 3; p++) begin
      rq[0].push_back({1'b1, 8'($urandom)});
      rq[2].push_back({1'b1, 8'($urandom)});
    end
    model_expect(npk);
    run(200, 1'b1);
    compare_stream("round_robin");
    check("rr_done", 32'(n_done), 6);

    // Backpressure in HDR (cycles 1..5) and in DATA (cycles 8..12).
    rq[1].push_back(9'h033);
    rq[1].push_back(9'h044);
    rq[1].push_back(9'h155);
    full_mask = 64'h0000_0000_0000_1F3E;
    txmode = 1;
    model_expect(npk);
    run(200, 1'b1);
    compare_stream("backpressure");
    check("bp_busy_cycles", 32'(busy_cyc), 15);
    check("bp_done", 32'(n_done), 1);

    // Randomized traffic with random backpressure and noise on idle lanes.
    txmode = 2;
    noise  = 1'b1;
    for (int r = 0; r < 8; r++) begin
      logic [NREQ-1:0] mask;
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) if (mask[i]) gen_pkts(i, int'($urandom_range(1, 2)));
      model_expect(npk);
      run(3000, 1'b1);
      compare_stream("random");
      check("random_done", 32'(n_done), 32'(npk));
      check("random_abort", 32'(n_abort), 0);
    end

    // Timeout: req3 sends 05 and goes quiet.
    txmode = 0;
    noise  = 1'b0;
    rq[3].push_back(9'h005);
    exp_q.delete();
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'h05);
    exp_q.push_back(8'h59);
    run(200, 1'b1);
    m_ptr = 3;
    compare_stream("timeout");
    check("timeout_abort", 32'(n_abort), 1);
    check("timeout_done", 32'(n_done), 0);
    check("timeout_stall_len", 32'(abort_cyc - last_xfer_cyc), 17);

    // After the abort, req0 is next in line.
    gen_pkts(0, 1);
    gen_pkts(1, 1);
    model_expect(npk);
    run(200, 1'b1);
    compare_stream("after_timeout");
    if (got_q.size() != 0) check("after_timeout_first_hdr", 32'(got_q[0]), 32'hA0);

    // Reset in the middle of the payload.
    rq[2].push_back(9'h0C1);
    rq[2].push_back(9'h0C2);
    rq[2].push_back(9'h0C3);
    rq[2].push_back(9'h1C4);
    run(4, 1'b0);
    reset = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    check_reset_outputs("midreset_held");
    reset = 1'b1;
    for (int i = 0; i < NREQ; i++) rq[i].delete();
    m_ptr = NREQ - 1;
    gen_pkts(2, 1);
    gen_pkts(0, 1);
    model_expect(npk);
    run(200, 1'b1);
    compare_stream("post_reset");
    if (got_q.size() != 0) check("post_reset_first_hdr", 32'(got_q[0]), 32'hA0);
    check("post_reset_done", 32'(n_done), 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
